implication_queue: RTL

//   Collects unit-clause implications from NUM_EVAL sub_clause_evaluator lanes and arbitrates one per cycle.

---
 rtl/implication_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/implication_queue.sv
// implication_queue
// Collects unit-clause implications from the evaluator lanes, accepts one per
// cycle by fixed lowest-index priority, and buffers them in a small FIFO.
// Each accepted implication is compared with every live entry. A repeat of the
// same implication is dropped. The same variable with the opposite value raises
// a sticky conflict. Entries drain in order through a valid/ready handshake.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module implication_queue #(
    parameter int NUM_EVAL = 4,
    parameter int DEPTH    = 8,
    parameter int VAR_BITS = `MAX_VARS_BITS
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NUM_EVAL-1:0]           in_unit,
    input  logic [NUM_EVAL-1:0]           in_val,
    input  logic [NUM_EVAL*VAR_BITS-1:0]  in_var,
    output logic [NUM_EVAL-1:0]           in_grant,
    output logic                          out_valid,
    output logic [VAR_BITS-1:0]           out_var,
    output logic                          out_val,
    input  logic                          out_ready,
    output logic                          conflict,
    output logic [VAR_BITS-1:0]           conflict_var,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [VAR_BITS-1:0] mem_var [DEPTH];
    logic [DEPTH-1:0]    mem_val;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                can_accept;
    logic                sel_hit;
    logic [VAR_BITS-1:0] sel_var;
    logic                sel_val;
    logic                dup_hit;
    logic                opp_hit;
    logic                push;
    logic                pop;
    logic                conf_set;
    logic                not_empty;

    // The grant depends only on occupancy, conflict, flush and reset. It never
    // depends on out_ready, so a full queue does not pass an entry through in
    // the cycle in which the head is popped.
    assign can_accept = reset_n && !flush && !conflict && (count < FULL_CNT);
    assign not_empty  = (count != '0);

    // Fixed-priority arbiter: the lowest-index requesting lane wins.
    always_comb begin
        // NOTE: give every combinational output a default first. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        in_grant = '0;
        sel_hit  = 1'b0;
        sel_var  = '0;
        sel_val  = 1'b0;
        for (int i = 0; i < NUM_EVAL; i++) begin
            if (can_accept && in_unit[i] && !sel_hit) begin
                sel_hit     = 1'b1;
                in_grant[i] = 1'b1;
                sel_var     = in_var[i*VAR_BITS +: VAR_BITS];
                sel_val     = in_val[i];
            end
        end
    end

    // Compare the winning lane with every live entry, including the head that
    // may leave on this same edge.
    always_comb begin
        logic [PTR_W-1:0] offset;
        dup_hit = 1'b0;
        opp_hit = 1'b0;
        offset  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            offset = PTR_W'(k) - rd_ptr;
            if ((CNT_W'(offset) < count) && (mem_var[k] == sel_var)) begin
                if (mem_val[k] == sel_val) dup_hit = 1'b1;
                else                       opp_hit = 1'b1;
            end
        end
    end

    assign push     = sel_hit && !dup_hit && !opp_hit;
    assign conf_set = sel_hit && opp_hit;
    assign pop      = out_valid && out_ready && !flush;

    assign out_valid = not_empty && !conflict;
    assign out_var   = not_empty ? mem_var[rd_ptr] : '0;
    assign out_val   = not_empty ? mem_val[rd_ptr] : 1'b0;

    // Pointers, occupancy and the sticky conflict. A flush overrides every
    // other update.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its pre-edge value regardless of statement order.
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (conf_set) begin
                conflict     <= 1'b1;
                conflict_var <= sel_var;
            end
        end
    end

    // Entry storage is written at the tail on each accepted push.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately left unreset. Occupancy alone decides
        // which entries are live, and the head outputs read as zero while the
        // queue is empty.
        if (push) begin
            mem_var[wr_ptr] <= sel_var;
            mem_val[wr_ptr] <= sel_val;
        end
    end

endmodule
